flag_branch_ctrl: RTL and testbench
===================================

Name: flag_branch_ctrl

Overview:
- Controller that owns the single shared 64-bit zero detector, the OR-reduce tree that feeds the EX stage.
- Time-shares the detector between two requesters: flag-setting ALU ops in EX, and CBZ/CBNZ operand checks in ID.
- Holds the architectural NZCV register and resolves CBZ/CBNZ/B.cond in ID.
- Stalls ID when both requesters collide, and keeps a stall statistic plus a starvation watchdog.

Parameters:
- STARVE_LIMIT, 8: consecutive ID stall cycles after which starve_err is set.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_sets_flags  in  1  EX instruction writes NZCV this cycle.
- ex_result  in  64  ALU result in EX.
- ex_carry  in  1  ALU carry-out.
- ex_ovf  in  1  ALU signed overflow.
- id_cbz_req  in  1  CBZ/CBNZ in ID.
- id_cbz_nz  in  1  1 = CBNZ, 0 = CBZ.
- id_cbz_val  in  64  forwarded register operand for CBZ/CBNZ.
- id_bcond_req  in  1  B.cond in ID.
- id_cond  in  4  B.cond condition code.
- zd_din  out  64  operand driven to the zero detector.
- zd_or  in  1  OR-reduce result of zd_din, combinational, same cycle.
- flags_q  out  4  architectural NZCV, bit 3 = N, bit 0 = V.
- branch_valid  out  1  ID branch resolved this cycle.
- branch_taken  out  1  resolved branch is taken; valid only with branch_valid.
- stall_id  out  1  hold the ID and IF stages this cycle.
- stall_cnt  out  CNT_W  saturating count of stall_id cycles.
- stat_clr  in  1  synchronous clear of stall_cnt.
- starve_err  out  1  sticky starvation flag.

Behaviour:
- Reset (async, any cycle, including mid-stall):
  - flags_q = 0000, stall_cnt = 0, starve_err = 0, FSM = IDLE.
  - Combinational outputs follow their inputs immediately.
- Detector arbitration (combinational):
  - EX has fixed priority, because it is the older instruction and the pipeline cannot stall EX.
  - ex_sets_flags = 1 → zd_din = ex_result.
  - Else id_cbz_req = 1 → zd_din = id_cbz_val.
  - Else zd_din = 0.
- Collision: id_cbz_req & ex_sets_flags → stall_id = 1 and branch_valid = 0. The CBZ retries next cycle with its operand held by ID.
- Flag update at the clock edge when ex_sets_flags = 1:
  - N = ex_result[63]
  - Z = ~zd_or
  - C = ex_carry
  - V = ex_ovf
  - Otherwise flags_q holds.
- CBZ/CBNZ, when granted (no stall):
  - branch_valid = 1.
  - branch_taken = ~zd_or for CBZ, zd_or for CBNZ.
  - Latency 0 (same cycle).
- B.cond never stalls.
  - Effective flags = next-flags when ex_sets_flags = 1 (forwarding), else flags_q.
  - branch_valid = 1; branch_taken = cond_eval(id_cond, effective flags).
- Condition evaluation:
  - EQ: Z. NE: !Z.
  - HS: C. LO: !C.
  - MI: N. PL: !N.
  - VS: V. VC: !V.
  - HI: C & !Z. LS: !(C & !Z).
  - GE: N == V. LT: N != V.
  - GT: !Z & (N == V). LE: !(GT).
  - AL (14) and NV (15): always taken.
- id_cbz_req and id_bcond_req both high is a decoder error. CBZ wins and the B.cond is ignored.
- stall_cnt:
  - Increments on every stall_id cycle.
  - Saturates at all-ones.
  - stat_clr has priority over increment (clears to 0).
- Starvation FSM, with a consecutive-stall counter run_cnt (clog2(STARVE_LIMIT+1) bits):
  - IDLE → WAIT on a stall cycle; run_cnt = 1.
  - WAIT with stall → run_cnt + 1.
  - WAIT without stall → IDLE; run_cnt = 0.
  - run_cnt reaching STARVE_LIMIT sets starve_err. It is sticky until reset.
  - The error is diagnostic only; arbitration does not change.
- No X-propagation: with no requests, branch_valid = 0, branch_taken = 0, stall_id = 0.

Decomposition:
- Shared package flag_pkg holds:
  - cond_e enum (EQ = 0 … NV = 15);
  - nzcv_t packed struct {n, z, c, v};
  - function cond_eval(cond_e, nzcv_t).
- The zero detector stays outside this block and connects via zd_din/zd_or. The bench may use a behavioural OR in its place.
- One natural sub-module: stall_monitor (stall_cnt, run_cnt, starve_err, FSM).

Test Plan:
- Reset, then ex_sets_flags = 1, ex_result = 0, carry = 1, ovf = 0 → after the edge, flags_q = 0110 (N = 0, Z = 1, C = 1, V = 0).
- CBZ in ID with id_cbz_val = 64'h0, no EX flag op → branch_valid = 1, branch_taken = 1, stall_id = 0. Repeat as CBNZ with 64'h8000_0000_0000_0000 → taken = 1.
- CBZ with ex_sets_flags = 1 in the same cycle → stall_id = 1, branch_valid = 0, zd_din = ex_result, stall_cnt becomes 1. The next cycle without the EX op resolves the CBZ.
- B.cond GT while EX sets flags from ex_result = 5, ovf = 0, and old flags_q = 0100 → forwarded flags 0000, taken = 1 (not 0 from stale Z).
- Hold the collision for 8 consecutive cycles → starve_err = 1 after the 8th edge and stays 1 when stalls stop. Assert reset mid-burst → everything clears asynchronously.
- Run stall_cnt to saturation with CNT_W = 4 → it stays at 15. Assert stat_clr together with a stall → stall_cnt = 0.

Source files
------------

// File: rtl/flag_pkg.sv
// Shared types for the NZCV flag / branch-resolution slice: condition codes,
// the flag word layout and the B.cond predicate.
package flag_pkg;

  typedef enum logic [3:0] {
    EQ, NE, HS, LO, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic {
    MON_IDLE,
    MON_WAIT
  } mon_state_e;

  function automatic logic cond_eval(input cond_e cond, input nzcv_t f);
    logic r;
    r = 1'b1;
    case (cond)
      EQ: r = f.z;
      NE: r = !f.z;
      HS: r = f.c;
      LO: r = !f.c;
      MI: r = f.n;
      PL: r = !f.n;
      VS: r = f.v;
      VC: r = !f.v;
      HI: r = f.c & !f.z;
      LS: r = !(f.c & !f.z);
      GE: r = (f.n == f.v);
      LT: r = (f.n != f.v);
      GT: r = !f.z & (f.n == f.v);
      LE: r = !(!f.z & (f.n == f.v));
      default: r = 1'b1;  // AL and NV
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_branch_ctrl_if.sv
// Bundle between the EX/ID pipeline, the shared zero detector and the
// flag/branch controller. slave = controller side, master = pipeline side.
interface flag_branch_ctrl_if #(
  parameter int CNT_W = 16
);
  import flag_pkg::*;

  // Handshake: branch_valid qualifies branch_taken for exactly one cycle and
  // only while stall_id is low; stall_id=1 is backpressure telling ID/IF to
  // hold the current instruction and present it again next cycle.
  logic             ex_sets_flags;
  logic [63:0]      ex_result;
  logic             ex_carry;
  logic             ex_ovf;
  logic             id_cbz_req;
  logic             id_cbz_nz;
  logic [63:0]      id_cbz_val;
  logic             id_bcond_req;
  logic [3:0]       id_cond;
  logic [63:0]      zd_din;
  logic             zd_or;
  logic [3:0]       flags_q;
  logic             branch_valid;
  logic             branch_taken;
  logic             stall_id;
  logic [CNT_W-1:0] stall_cnt;
  logic             stat_clr;
  logic             starve_err;
  mon_state_e       mon_state;

  modport slave (
    input  ex_sets_flags, ex_result, ex_carry, ex_ovf,
    input  id_cbz_req, id_cbz_nz, id_cbz_val, id_bcond_req, id_cond,
    input  zd_or, stat_clr,
    output zd_din, flags_q, branch_valid, branch_taken, stall_id,
    output stall_cnt, starve_err, mon_state
  );

  modport master (
    output ex_sets_flags, ex_result, ex_carry, ex_ovf,
    output id_cbz_req, id_cbz_nz, id_cbz_val, id_bcond_req, id_cond,
    output zd_or, stat_clr,
    input  zd_din, flags_q, branch_valid, branch_taken, stall_id,
    input  stall_cnt, starve_err, mon_state
  );

endinterface

// File: rtl/stall_monitor.sv
// Stall statistics: saturating stall-cycle counter plus a consecutive-stall
// watchdog FSM that raises a sticky starvation flag.
module stall_monitor
  import flag_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             starve_err,
  output mon_state_e       state
);

  localparam int RUN_W = $clog2(STARVE_LIMIT + 1);

  mon_state_e       state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MON_IDLE;
      run_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    case (state_q)
      MON_IDLE: begin
        if (stall) begin
          state_d = MON_WAIT;
          run_d   = RUN_W'(1);
        end
      end
      MON_WAIT: begin
        if (stall) begin
          // Hold at the limit so a long burst cannot wrap the run counter.
          if (run_q != RUN_W'(STARVE_LIMIT)) run_d = run_q + 1'b1;
        end else begin
          state_d = MON_IDLE;
          run_d   = '0;
        end
      end
      default: begin
        state_d = MON_IDLE;
        run_d   = '0;
      end
    endcase

    err_d = err_q | (run_d == RUN_W'(STARVE_LIMIT));

    cnt_d = cnt_q;
    if (stat_clr)                  cnt_d = '0;
    else if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  assign stall_cnt  = cnt_q;
  assign starve_err = err_q;
  assign state      = state_q;

endmodule

// File: rtl/flag_branch_ctrl.sv
// Owns the shared zero detector port, the NZCV register and same-cycle
// resolution of CBZ/CBNZ/B.cond in ID; EX always wins the detector.
module flag_branch_ctrl
  import flag_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                reset,
  flag_branch_ctrl_if.slave  bus
);

  nzcv_t flags_r;
  nzcv_t next_flags;
  nzcv_t eff_flags;
  logic  collide;
  logic  br_valid;
  logic  br_taken;
  logic  [63:0] zd_sel;

  always_comb begin
    zd_sel = 64'd0;
    if (bus.ex_sets_flags)   zd_sel = bus.ex_result;
    else if (bus.id_cbz_req) zd_sel = bus.id_cbz_val;
  end

  // zd_or reflects whichever operand won the detector this cycle.
  always_comb begin
    next_flags = '{n: bus.ex_result[63], z: ~bus.zd_or,
                   c: bus.ex_carry,      v: bus.ex_ovf};
    eff_flags  = bus.ex_sets_flags ? next_flags : flags_r;
    collide    = bus.id_cbz_req & bus.ex_sets_flags;

    br_valid = 1'b0;
    br_taken = 1'b0;
    if (bus.id_cbz_req) begin
      // A simultaneous B.cond is a decode error; the CBZ alone is serviced.
      if (!bus.ex_sets_flags) begin
        br_valid = 1'b1;
        br_taken = bus.id_cbz_nz ? bus.zd_or : ~bus.zd_or;
      end
    end else if (bus.id_bcond_req) begin
      br_valid = 1'b1;
      br_taken = cond_eval(cond_e'(bus.id_cond), eff_flags);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  flags_r <= '0;
    else if (bus.ex_sets_flags) flags_r <= next_flags;
  end

  assign bus.zd_din       = zd_sel;
  assign bus.flags_q      = flags_r;
  assign bus.branch_valid = br_valid;
  assign bus.branch_taken = br_taken;
  assign bus.stall_id     = collide;

  stall_monitor #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_stall_monitor (
    .clk        (clk),
    .reset      (reset),
    .stall      (collide),
    .stat_clr   (bus.stat_clr),
    .stall_cnt  (bus.stall_cnt),
    .starve_err (bus.starve_err),
    .state      (bus.mon_state)
  );

endmodule

// File: tb/tb_flag_branch_ctrl.sv
// Directed bench for flag_branch_ctrl: branch outcomes go through an expected
// queue drained by a monitor; flags and statistics are checked after edges.
module tb_flag_branch_ctrl;
  import flag_pkg::*;

  localparam int CNT_W        = 4;
  localparam int STARVE_LIMIT = 8;
  localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic exp_q[$];

  flag_branch_ctrl_if #(.CNT_W(CNT_W)) bus ();

  // Behavioural stand-in for the shared OR-reduce tree.
  assign bus.zd_or = |bus.zd_din;

  flag_branch_ctrl #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every resolved branch must match the oldest expected outcome.
  always @(negedge clk) begin
    if (!reset && bus.branch_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL branch_unexpected: got taken=%0b expected no branch", bus.branch_taken);
      end else begin
        logic e;
        e = exp_q.pop_front();
        if (bus.branch_taken !== e) begin
          n_bad++;
          $display("FAIL branch_taken: got %0b expected %0b", bus.branch_taken, e);
        end
      end
    end
  end

  // Driver: apply one cycle of inputs just after an edge, check the
  // combinational stall/detector outputs mid-cycle, then advance one edge.
  task automatic drive(input logic sf, input logic [63:0] res, input logic c, input logic o,
                       input logic cbz, input logic nz, input logic [63:0] cv,
                       input logic bc, input logic [3:0] cond, input logic clr,
                       input logic exp_stall, input logic [63:0] exp_zd);
    bus.ex_sets_flags = sf;
    bus.ex_result     = res;
    bus.ex_carry      = c;
    bus.ex_ovf        = o;
    bus.id_cbz_req    = cbz;
    bus.id_cbz_nz     = nz;
    bus.id_cbz_val    = cv;
    bus.id_bcond_req  = bc;
    bus.id_cond       = cond;
    bus.stat_clr      = clr;
    #2;
    check("stall_id", 64'(bus.stall_id), 64'(exp_stall));
    check("zd_din", bus.zd_din, exp_zd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 64'd0);
  endtask

  task automatic bcond(input logic [3:0] cond, input logic exp_taken);
    exp_q.push_back(exp_taken);
    drive(0, 0, 0, 0, 0, 0, 0, 1, cond, 0, 0, 64'd0);
  endtask

  task automatic collide(input logic [63:0] res, input logic clr);
    drive(1, res, 1, 1, 1, 0, 64'd0, 0, 4'd0, clr, 1, res);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.ex_sets_flags = 0; bus.ex_result = 0; bus.ex_carry = 0; bus.ex_ovf = 0;
    bus.id_cbz_req = 0; bus.id_cbz_nz = 0; bus.id_cbz_val = 0;
    bus.id_bcond_req = 0; bus.id_cond = 0; bus.stat_clr = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_flags", 64'(bus.flags_q), 64'h0);
    check("reset_stall_cnt", 64'(bus.stall_cnt), 64'h0);
    check("reset_starve", 64'(bus.starve_err), 64'h0);
    check("reset_state", 64'(bus.mon_state), 64'(MON_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Flag write from a zero result
    drive(1, 64'd0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 64'd0);
    check("flags_zero_result", 64'(bus.flags_q), 64'b0110);

    // CBZ / CBNZ granted same cycle
    exp_q.push_back(1'b1); drive(0, 0, 0, 0, 1, 0, 64'd0, 0, 4'd0, 0, 0, 64'd0);
    exp_q.push_back(1'b1); drive(0, 0, 0, 0, 1, 1, MSB,   0, 4'd0, 0, 0, MSB);
    exp_q.push_back(1'b0); drive(0, 0, 0, 0, 1, 0, 64'd5, 0, 4'd0, 0, 0, 64'd5);
    exp_q.push_back(1'b0); drive(0, 0, 0, 0, 1, 1, 64'd0, 0, 4'd0, 0, 0, 64'd0);

    // Collision: EX owns the detector, CBZ stalls then resolves
    drive(1, 64'h1234, 0, 0, 1, 0, 64'd0, 0, 4'd0, 0, 1, 64'h1234);
    check("collide_stall_cnt", 64'(bus.stall_cnt), 64'd1);
    check("collide_flags", 64'(bus.flags_q), 64'b0000);
    exp_q.push_back(1'b1); drive(0, 0, 0, 0, 1, 0, 64'd0, 0, 4'd0, 0, 0, 64'd0);

    // B.cond GT with forwarded flags beats stale Z
    drive(1, 64'd0, 0, 0, 0, 0, 0, 0, 4'd0, 0, 0, 64'd0);
    check("flags_z_only", 64'(bus.flags_q), 64'b0100);
    exp_q.push_back(1'b1); drive(1, 64'd5, 0, 0, 0, 0, 0, 1, 4'd12, 0, 0, 64'd5);
    check("flags_after_fwd", 64'(bus.flags_q), 64'b0000);
    bcond(4'd0, 1'b0);   // EQ with Z=0

    // Flags N=1 Z=0 C=1 V=0, then a spread of conditions
    drive(1, MSB, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, MSB);
    check("flags_n_c", 64'(bus.flags_q), 64'b1010);
    bcond(4'd11, 1'b1);  // LT
    bcond(4'd10, 1'b0);  // GE
    bcond(4'd8,  1'b1);  // HI
    bcond(4'd9,  1'b0);  // LS
    bcond(4'd4,  1'b1);  // MI
    bcond(4'd6,  1'b0);  // VS
    bcond(4'd14, 1'b1);  // AL
    bcond(4'd15, 1'b1);  // NV

    // Decode error: CBZ wins over a simultaneous B.cond AL
    exp_q.push_back(1'b0); drive(0, 0, 0, 0, 1, 0, 64'd7, 1, 4'd14, 0, 0, 64'd7);

    // No requests: outputs quiet
    idle();
    #2;
    check("idle_valid", 64'(bus.branch_valid), 64'd0);
    check("idle_taken", 64'(bus.branch_taken), 64'd0);
    @(posedge clk);
    #1;

    // Starvation watchdog
    for (int i = 0; i < STARVE_LIMIT - 1; i++) collide(MSB, 0);
    check("starve_before_limit", 64'(bus.starve_err), 64'd0);
    check("stall_cnt_8", 64'(bus.stall_cnt), 64'd8);
    check("state_wait", 64'(bus.mon_state), 64'(MON_WAIT));
    collide(MSB, 0);
    check("starve_at_limit", 64'(bus.starve_err), 64'd1);
    check("stall_cnt_9", 64'(bus.stall_cnt), 64'd9);
    idle();
    check("starve_sticky", 64'(bus.starve_err), 64'd1);
    check("state_idle", 64'(bus.mon_state), 64'(MON_IDLE));

    // Asynchronous reset in the middle of a stall burst
    collide(MSB, 0);
    collide(MSB, 0);
    check("flags_before_reset", 64'(bus.flags_q), 64'b1011);
    bus.ex_sets_flags = 1; bus.ex_result = MSB; bus.id_cbz_req = 1;
    #2;
    reset = 1'b1;
    #1;
    check("async_flags", 64'(bus.flags_q), 64'h0);
    check("async_stall_cnt", 64'(bus.stall_cnt), 64'h0);
    check("async_starve", 64'(bus.starve_err), 64'h0);
    check("async_state", 64'(bus.mon_state), 64'(MON_IDLE));
    bus.ex_sets_flags = 0; bus.ex_result = 0; bus.id_cbz_req = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Saturation and clear priority
    for (int i = 0; i < 15; i++) collide(64'd1, 0);
    check("stall_cnt_15", 64'(bus.stall_cnt), 64'd15);
    collide(64'd1, 0);
    check("stall_cnt_sat", 64'(bus.stall_cnt), 64'd15);
    collide(64'd1, 1);
    check("stall_cnt_clr", 64'(bus.stall_cnt), 64'd0);
    collide(64'd1, 0);
    check("stall_cnt_after_clr", 64'(bus.stall_cnt), 64'd1);

    idle();
    idle();
    check("branch_queue_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
